// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage and the next-PC logic.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package if_fetch_unit_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_FLUSH = 2'd2
  } if_state_e;

  // Default first fetch address after reset.
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // Sequential PC step; the next-PC logic uses the same constant.
  localparam logic [31:0] PC_INC = 32'd4;

  // One buffered instruction: its PC and the fetched word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } if_entry_t;

  // Force a target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// Small synchronous FIFO that holds fetched {pc, word} entries for decode.
// Latency: a push is visible at the head on the next cycle (no bypass).
// Backpressure: none internally; clear empties it, winning over push.
// Ports: push/push_data write the tail, pop drops the head, clear empties
//        the FIFO, head is the oldest entry, count is the current occupancy.
module if_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop & (count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & ~clear & ((count != FULL_CNT) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      // A concurrent pop is consumed by the downstream stage; either way the
      // FIFO ends up empty.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues sequential requests to an in-order, variable
// latency instruction memory and buffers the returned words for decode.
// Latency: imem_rvalid in cycle N gives inst_valid in cycle N+1.
// Backpressure: requests stop while outstanding + buffered reaches BUF_DEPTH;
//   decode stalls by holding inst_ready low.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   en                        fetch enable
//   imem_req/addr/gnt         request side of the instruction memory
//   imem_rvalid/rdata         in-order response side
//   inst_valid/inst/inst_pc   buffer head towards decode, inst_ready pops it
//   redirect/redirect_pc      non-sequential next PC from the next-PC logic
//   align_err                 sticky: a redirect target was not word aligned
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        align_err
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(BUF_DEPTH);

  if_state_e        state;
  if_state_e        state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_nxt;
  logic [31:0]      resp_pc;
  logic [31:0]      resp_pc_nxt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_cnt_nxt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_cnt_nxt;
  logic [CNT_W-1:0] redir_left;
  logic [CNT_W-1:0] buf_count;
  logic             align_err_nxt;

  logic             below_cap;
  logic             grant;
  logic             rsp;
  logic             accept;
  logic             pop;
  logic             flush_buf;
  if_entry_t        push_entry;
  if_entry_t        head;
  if_entry_t        held;

  // Cap counts requests in flight plus words already buffered, so every
  // response that comes back is guaranteed a buffer slot.
  assign below_cap = ({1'b0, out_cnt} + {1'b0, buf_count}) < CAP;
  assign imem_req  = (state == IF_FETCH) & en & ~redirect & below_cap;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;

  // A response only counts when something is in flight, including a request
  // granted in this very cycle. This discards stale responses that survive a
  // reset until a new request is granted.
  assign rsp       = imem_rvalid & ((out_cnt != '0) | grant);
  assign accept    = rsp & (state == IF_FETCH) & ~redirect;

  assign inst_valid = (buf_count != '0);
  assign pop        = inst_valid & inst_ready;
  assign flush_buf  = redirect & (state != IF_IDLE);
  assign push_entry = '{pc: resp_pc, word: imem_rdata};

  // While the buffer is empty decode keeps seeing the last head it was shown.
  assign inst    = inst_valid ? head.word : held.word;
  assign inst_pc = inst_valid ? head.pc   : held.pc;

  if_inst_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(if_entry_t)),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (flush_buf),
    .head      (head),
    .count     (buf_count)
  );

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    resp_pc_nxt   = resp_pc;
    out_cnt_nxt   = out_cnt;
    drop_cnt_nxt  = drop_cnt;
    align_err_nxt = align_err;
    redir_left    = '0;

    case ({grant, rsp})
      2'b10:   out_cnt_nxt = out_cnt + CNT_W'(1);
      2'b01:   out_cnt_nxt = out_cnt - CNT_W'(1);
      default: out_cnt_nxt = out_cnt;
    endcase

    if (grant) begin
      fetch_pc_nxt = fetch_pc + PC_INC;
    end
    if (accept) begin
      resp_pc_nxt = resp_pc + PC_INC;
    end

    case (state)
      IF_IDLE: begin
        if (en) begin
          state_nxt = IF_FETCH;
        end
      end
      IF_FETCH: begin
        state_nxt = IF_FETCH;
      end
      IF_FLUSH: begin
        // Every response seen here belongs to the abandoned path.
        if (rsp) begin
          drop_cnt_nxt = drop_cnt - CNT_W'(1);
          if (drop_cnt == CNT_W'(1)) begin
            state_nxt = IF_FETCH;
          end
        end
      end
      default: begin
        state_nxt = IF_IDLE;
      end
    endcase

    if (redirect) begin
      fetch_pc_nxt = word_align(redirect_pc);
      resp_pc_nxt  = word_align(redirect_pc);
      if (state != IF_IDLE) begin
        // Everything still in flight after this cycle is wrong-path. No
        // request is granted during a redirect, so only rsp reduces it.
        redir_left   = ((state == IF_FLUSH) ? drop_cnt : out_cnt) - CNT_W'(rsp);
        drop_cnt_nxt = redir_left;
        state_nxt    = (redir_left != '0) ? IF_FLUSH : IF_FETCH;
        if (redirect_pc[1:0] != 2'b00) begin
          align_err_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IF_IDLE;
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      out_cnt   <= '0;
      drop_cnt  <= '0;
      align_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      resp_pc   <= resp_pc_nxt;
      out_cnt   <= out_cnt_nxt;
      drop_cnt  <= drop_cnt_nxt;
      align_err <= align_err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
    end else if (inst_valid) begin
      held <= head;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: randomized memory/decode/redirect
// stimulus against a queue-based reference model of the fetch stage.
// Responses are tagged with the redirect epoch they were requested in.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          D   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        align_err;

  if_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .align_err   (align_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; int ep;} infl_t;
  typedef struct {logic [31:0] pc; logic [31:0] w;} ent_t;

  // Reference model state.
  infl_t       m_infl[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_w;
  int          m_ep;
  bit          m_started;
  bit          m_align;

  // Memory environment and logs.
  int          mem_due[$];
  logic [31:0] dlv[$];
  logic [31:0] gnt_log[$];
  int          pops;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Stimulus knobs.
  int          p_gnt = 100, p_rdy = 100, p_redir = 0, p_en = 100;
  int          lat_lo = 0, lat_hi = 0;
  bit          stray = 0;
  bit          redir_busy = 0;
  bit          busy_fired = 0;
  logic [31:0] busy_pc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_flushing();
    foreach (m_infl[i]) begin
      if (m_infl[i].ep != m_ep) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cycle(input bit f_redir = 1'b0, input logic [31:0] f_pc = '0);
    bit    will_rsp;
    bit    busy_now;
    bit    exp_req;
    infl_t e;
    @(posedge clk);
    #1;
    cyc++;
    en         = ($urandom_range(99) < p_en);
    imem_gnt   = ($urandom_range(99) < p_gnt);
    inst_ready = ($urandom_range(99) < p_rdy);
    will_rsp   = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    busy_now   = redir_busy && !busy_fired && will_rsp && inst_ready &&
                 (m_buf.size() > 0) && (m_infl.size() == 1);
    redirect_pc = $urandom & 32'h0000_03FC;
    if ($urandom_range(7) == 0) redirect_pc = redirect_pc | ($urandom & 32'h3);
    if (f_redir) redirect_pc = f_pc;
    if (busy_now) begin
      redirect_pc = busy_pc;
      busy_fired  = 1'b1;
    end
    redirect    = f_redir || busy_now || ($urandom_range(99) < p_redir);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    #1;
    exp_req = m_started && en && !redirect && !m_flushing() &&
              ((m_infl.size() + m_buf.size()) < D);
    check("imem_req", imem_req, exp_req);
    check("imem_addr", imem_addr, m_pc);
    if (imem_req && imem_gnt) begin
      gnt_log.push_back(imem_addr);
      mem_due.push_back(cyc + $urandom_range(lat_hi, lat_lo));
    end
    if ((mem_due.size() > 0) && (mem_due[0] <= cyc)) begin
      void'(mem_due.pop_front());
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else if (stray) begin
      imem_rvalid = ($urandom_range(1) == 1);
      imem_rdata  = $urandom;
    end
    #1;
    check("inst_valid", inst_valid, m_buf.size() > 0);
    if (m_buf.size() > 0) begin
      m_last_pc = m_buf[0].pc;
      m_last_w  = m_buf[0].w;
    end
    check("inst_pc", inst_pc, m_last_pc);
    check("inst", inst, m_last_w);
    check("align_err", align_err, m_align);

    // Advance the model by one clock edge.
    if (exp_req && imem_gnt) begin
      m_infl.push_back('{pc: m_pc, ep: m_ep});
      m_pc = m_pc + 32'd4;
    end
    if ((m_buf.size() > 0) && inst_ready) begin
      dlv.push_back(m_buf[0].pc);
      void'(m_buf.pop_front());
      pops++;
    end
    if (imem_rvalid && (m_infl.size() > 0)) begin
      e = m_infl.pop_front();
      if ((e.ep == m_ep) && !redirect) m_buf.push_back('{pc: e.pc, w: imem_rdata});
    end
    if (redirect) begin
      if (m_started) begin
        m_buf.delete();
        m_ep++;
        if (redirect_pc[1:0] != 2'b00) m_align = 1'b1;
      end
      m_pc = {redirect_pc[31:2], 2'b00};
    end
    if (en) m_started = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_align", align_err, 0);
    en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m_infl.delete(); m_buf.delete(); mem_due.delete(); dlv.delete(); gnt_log.delete();
    m_pc = RPC; m_last_pc = '0; m_last_w = '0; m_ep = 0; m_started = 1'b0; m_align = 1'b0;
    pops = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int p0;
    int i;

    // 1: back-to-back fetch with same-cycle responses, decode always ready.
    do_reset();
    p_gnt = 100; p_rdy = 100; p_redir = 0; p_en = 100; lat_lo = 0; lat_hi = 0;
    repeat (2) cycle();
    check("t1_first_req", imem_req, 1);
    check("t1_first_addr", imem_addr, 32'h0);
    repeat (2) cycle();
    p0 = pops;
    repeat (8) cycle();
    check("t1_throughput", pops - p0, 8);
    check("t1_pc0", dlv[0], 32'h0);
    check("t1_pc1", dlv[1], 32'h4);
    check("t1_pc2", dlv[2], 32'h8);

    // 2: decode stalled, buffer fills and requests stop; then drains in order.
    do_reset();
    p_rdy = 0;
    repeat (8) cycle();
    check("t2_req_stall", imem_req, 0);
    check("t2_head_pc", inst_pc, 32'h0);
    p_rdy = 100;
    repeat (3) cycle();
    check("t2_drain0", dlv[0], 32'h0);
    check("t2_drain1", dlv[1], 32'h4);

    // 3: redirect with two fetches in flight, both discarded.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (i = 0; i < 50 && !(m_infl.size() == 2 && m_infl[0].pc == 32'h8); i++) cycle();
    check("t3_reach", (m_infl.size() == 2) ? m_infl[1].pc : 32'hDEAD_BEEF, 32'hC);
    cycle(1'b1, 32'h40);
    repeat (12) cycle();
    check("t3_gnt_after", (gnt_log.size() > 4) ? gnt_log[4] : 32'hDEAD_BEEF, 32'h40);
    check("t3_dlv_after", (dlv.size() > 2) ? dlv[2] : 32'hDEAD_BEEF, 32'h40);

    // 4: redirect coinciding with a response and a pop, one fetch in flight.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    redir_busy = 1'b1; busy_fired = 1'b0; busy_pc = 32'h80;
    for (i = 0; i < 50 && !busy_fired; i++) cycle();
    redir_busy = 1'b0;
    check("t4_fired", busy_fired, 1);
    check("t4_popped", (dlv.size() > 0) ? dlv[dlv.size()-1] : 32'hDEAD_BEEF, 32'h0);
    cycle();
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 32'h80);
    p0 = dlv.size();
    repeat (4) cycle();
    check("t4_next_pc", (dlv.size() > p0) ? dlv[p0] : 32'hDEAD_BEEF, 32'h80);

    // 5: misaligned redirect sets the sticky flag and is word aligned.
    cycle(1'b1, 32'h0000_0042);
    cycle();
    check("t5_align", align_err, 1);
    check("t5_addr", imem_addr, 32'h40);
    cycle(1'b1, 32'h100);
    repeat (3) cycle();
    check("t5_sticky", align_err, 1);

    // 6: reset while flushing, then stale responses before any new grant.
    do_reset();
    lat_lo = 4; lat_hi = 4;
    for (i = 0; i < 50 && m_infl.size() < 2; i++) cycle();
    cycle(1'b1, 32'h200);
    for (i = 0; i < 50 && m_infl.size() > 1; i++) cycle();
    check("t6_flush1", m_infl.size(), 1);
    do_reset();
    p_gnt = 0; stray = 1'b1;
    repeat (6) cycle();
    check("t6_no_valid", inst_valid, 0);
    stray = 1'b0; p_gnt = 100; lat_lo = 1; lat_hi = 1;
    repeat (6) cycle();
    check("t6_restart", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, RPC);

    // 7: randomized traffic with redirects, stalls and latency jitter.
    do_reset();
    p_gnt = 70; p_rdy = 60; p_redir = 5; p_en = 90; lat_lo = 0; lat_hi = 3;
    repeat (2500) cycle();
    do_reset();
    p_gnt = 40; p_rdy = 85; p_redir = 10; p_en = 75; lat_lo = 1; lat_hi = 5;
    repeat (2500) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
